// File: rtl/ohc_to_binary_pipe.sv
// One-hot residue to binary converter behind a single-entry valid/ready output register.
// Malformed codes (no hot bit or several) yield bin 0 with err set and bump a saturating counter.
module ohc_to_binary_pipe #(
    parameter int unsigned M         = 9,
    parameter int unsigned OUT_W     = $clog2(M),
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [M-1:0]         in_ohc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_bin,
    output logic                 out_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [OUT_W-1:0]       bin_q, bin_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;

    logic                   seen_c;
    logic                   multi_c;
    logic [OUT_W-1:0]       idx_c;
    logic                   bad_c;
    logic [OUT_W-1:0]       bin_c;
    logic                   accept_c;

    // Decode: a second hot bit after the first marks the code as multi-hot.
    always_comb begin
        seen_c  = 1'b0;
        multi_c = 1'b0;
        idx_c   = '0;
        for (int k = 0; k < int'(M); k++) begin
            if (in_ohc[k]) begin
                multi_c = multi_c | seen_c;
                seen_c  = 1'b1;
                idx_c   = OUT_W'(k);
            end
        end
        bad_c = multi_c || !seen_c;
        bin_c = bad_c ? '0 : idx_c;
    end

    assign in_ready = (state_q == S_EMPTY) || out_ready;
    assign accept_c = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_EMPTY: begin
                if (accept_c) begin
                    state_d = S_FULL;
                    bin_d   = bin_c;
                    err_d   = bad_c;
                end
            end
            S_FULL: begin
                if (accept_c) begin
                    bin_d = bin_c;
                    err_d = bad_c;
                end else if (out_ready) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        // Clear takes priority over a same-cycle malformed accept.
        if (err_clr) begin
            cnt_d = '0;
        end else if (accept_c && bad_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            bin_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == S_FULL);
    assign out_bin   = bin_q;
    assign out_err   = err_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_ohc_to_binary_pipe.sv
// Bench for ohc_to_binary_pipe: directed scenarios over four parameterisations plus a
// randomized run of the M=9 instance against an arithmetic reference model.
module tb_ohc_to_binary_pipe;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    // Main instance: M=9, ERR_CNT_W=8
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err, a_err_clr;
    logic [8:0] a_in_ohc;
    logic [3:0] a_out_bin;
    logic [7:0] a_err_cnt;

    // Saturation instance: M=9, ERR_CNT_W=3
    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err, s_err_clr;
    logic [8:0] s_in_ohc;
    logic [3:0] s_out_bin;
    logic [2:0] s_err_cnt;

    // M=2 instance
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err, b_err_clr;
    logic [1:0] b_in_ohc;
    logic [0:0] b_out_bin;
    logic [7:0] b_err_cnt;

    // M=17 instance
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_err, c_err_clr;
    logic [16:0] c_in_ohc;
    logic [4:0]  c_out_bin;
    logic [7:0]  c_err_cnt;

    ohc_to_binary_pipe #(.M(9), .ERR_CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ohc(a_in_ohc), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_bin(a_out_bin), .out_err(a_out_err), .err_clr(a_err_clr), .err_cnt(a_err_cnt)
    );

    ohc_to_binary_pipe #(.M(9), .ERR_CNT_W(3)) u_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_ohc(s_in_ohc), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_bin(s_out_bin), .out_err(s_out_err), .err_clr(s_err_clr), .err_cnt(s_err_cnt)
    );

    ohc_to_binary_pipe #(.M(2), .ERR_CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ohc(b_in_ohc), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_bin(b_out_bin), .out_err(b_out_err), .err_clr(b_err_clr), .err_cnt(b_err_cnt)
    );

    ohc_to_binary_pipe #(.M(17), .ERR_CNT_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_ohc(c_in_ohc), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_bin(c_out_bin), .out_err(c_out_err), .err_clr(c_err_clr), .err_cnt(c_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a legal code is a power of two, whose log2 is the residue.
    function automatic int ref_bin(input logic [63:0] code);
        return ($countones(code) == 1) ? $clog2(code) : 0;
    endfunction

    function automatic logic ref_bad(input logic [63:0] code);
        return $countones(code) != 1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if (a_out_valid !== 1'b0 || a_out_bin !== 4'd0 || a_out_err !== 1'b0 || a_err_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b bin=%0d err=%b cnt=%0d, required 0/0/0/0",
                     a_out_valid, a_out_bin, a_out_err, a_err_cnt);
        end
        vectors++;
        if (a_in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: a=%b s=%b, required 1", a_in_ready, s_in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: in_ready=%b out_valid=%b, required 1/0", a_in_ready, a_out_valid);
        end
    endtask

    task automatic test_stream();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int k = 0; k < 9; k++) begin
            a_in_ohc = 9'(1) << k;
            #1;
            vectors++;
            if (a_in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_ready[%0d]: got %b, required 1", k, a_in_ready);
            end
            tick();
            vectors++;
            if (a_out_valid !== 1'b1 || a_out_bin !== 4'(k) || a_out_err !== 1'b0 || a_err_cnt !== 8'd0) begin
                miscompares++;
                $display("FAIL stream_out[%0d]: valid=%b bin=%0d err=%b cnt=%0d, required 1/%0d/0/0",
                         k, a_out_valid, a_out_bin, a_out_err, a_err_cnt, k);
            end
        end
        a_in_valid = 1'b0;
        tick();
        vectors++;
        if (a_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_drain: out_valid=%b, required 0", a_out_valid);
        end
    endtask

    task automatic test_malformed();
        logic [8:0] codes [2];
        codes[0] = 9'b000000000;
        codes[1] = 9'b000010010;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_in_ohc = codes[i];
            tick();
            vectors++;
            if (a_out_valid !== 1'b1 || a_out_bin !== 4'd0 || a_out_err !== 1'b1 || a_err_cnt !== 8'(i + 1)) begin
                miscompares++;
                $display("FAIL malformed[%0d]: valid=%b bin=%0d err=%b cnt=%0d, required 1/0/1/%0d",
                         i, a_out_valid, a_out_bin, a_out_err, a_err_cnt, i + 1);
            end
        end
        a_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_ohc    = 9'b000100000;
        tick();
        a_out_ready = 1'b0;
        a_in_ohc    = 9'b000000100;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (a_in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_ready[%0d]: got %b, required 0", i, a_in_ready);
            end
            tick();
            vectors++;
            if (a_out_valid !== 1'b1 || a_out_bin !== 4'd5 || a_out_err !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: valid=%b bin=%0d err=%b, required 1/5/0",
                         i, a_out_valid, a_out_bin, a_out_err);
            end
        end
        a_out_ready = 1'b1;
        #1;
        vectors++;
        if (a_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release_ready: got %b, required 1", a_in_ready);
        end
        tick();
        vectors++;
        if (a_out_valid !== 1'b1 || a_out_bin !== 4'd2 || a_err_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL bp_release_out: valid=%b bin=%0d cnt=%0d, required 1/2/2",
                     a_out_valid, a_out_bin, a_err_cnt);
        end
        a_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        int exp_cnt;
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        s_err_clr   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_in_ohc = (i % 2 == 1) ? 9'h003 : 9'h000;
            tick();
            exp_cnt = (i + 1 > 7) ? 7 : i + 1;
            vectors++;
            if (s_err_cnt !== 3'(exp_cnt) || s_out_err !== 1'b1) begin
                miscompares++;
                $display("FAIL sat[%0d]: cnt=%0d err=%b, required %0d/1", i, s_err_cnt, s_out_err, exp_cnt);
            end
        end
        s_in_ohc  = 9'h1FF;
        s_err_clr = 1'b1;
        tick();
        vectors++;
        if (s_err_cnt !== 3'd0 || s_out_err !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_clear: cnt=%0d err=%b, required 0/1", s_err_cnt, s_out_err);
        end
        s_err_clr  = 1'b0;
        s_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_param();
        logic [1:0] bcode [3];
        bcode[0] = 2'b01;
        bcode[1] = 2'b10;
        bcode[2] = 2'b11;
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_in_ohc = bcode[i];
            tick();
            vectors++;
            if (b_out_valid !== 1'b1 || b_out_bin !== 1'(ref_bin(64'(bcode[i])))
                || b_out_err !== ref_bad(64'(bcode[i]))) begin
                miscompares++;
                $display("FAIL m2[%0d]: bin=%0d err=%b, required %0d/%b", i, b_out_bin, b_out_err,
                         ref_bin(64'(bcode[i])), ref_bad(64'(bcode[i])));
            end
        end
        b_in_valid  = 1'b0;
        c_out_ready = 1'b1;
        c_in_valid  = 1'b1;
        for (int k = 0; k < 17; k++) begin
            c_in_ohc = 17'(1) << k;
            tick();
            vectors++;
            if (c_out_valid !== 1'b1 || c_out_bin !== 5'(k) || c_out_err !== 1'b0) begin
                miscompares++;
                $display("FAIL m17[%0d]: valid=%b bin=%0d err=%b, required 1/%0d/0",
                         k, c_out_valid, c_out_bin, c_out_err, k);
            end
        end
        c_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic       exp_full;
        int         exp_bin;
        logic       exp_err;
        int         exp_cnt;
        logic       exp_rdy;
        logic       acc;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        exp_full = 1'b0;
        exp_bin  = 0;
        exp_err  = 1'b0;
        exp_cnt  = 0;
        for (int n = 0; n < 400; n++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_err_clr   = ($urandom_range(0, 29) == 0);
            a_in_ohc    = ($urandom_range(0, 1) == 1) ? (9'(1) << $urandom_range(0, 8)) : 9'($urandom);
            #1;
            exp_rdy = !exp_full || a_out_ready;
            vectors++;
            if (a_in_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL rnd_ready[%0d]: got %b, required %b", n, a_in_ready, exp_rdy);
            end
            acc = a_in_valid && exp_rdy;
            if (acc) begin
                exp_full = 1'b1;
                exp_bin  = ref_bin(64'(a_in_ohc));
                exp_err  = ref_bad(64'(a_in_ohc));
            end else if (a_out_ready) begin
                exp_full = 1'b0;
            end
            if (a_err_clr) exp_cnt = 0;
            else if (acc && ref_bad(64'(a_in_ohc)) && exp_cnt < 255) exp_cnt++;
            tick();
            vectors++;
            if (a_out_valid !== exp_full || a_err_cnt !== 8'(exp_cnt)
                || (exp_full && (a_out_bin !== 4'(exp_bin) || a_out_err !== exp_err))) begin
                miscompares++;
                $display("FAIL rnd_out[%0d]: valid=%b bin=%0d err=%b cnt=%0d, required %b/%0d/%b/%0d",
                         n, a_out_valid, a_out_bin, a_out_err, a_err_cnt,
                         exp_full, exp_bin, exp_err, exp_cnt);
            end
        end
        a_in_valid = 1'b0;
        a_err_clr  = 1'b0;
        a_out_ready = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_err_clr   = 1'b1;
        a_in_ohc    = 9'h000;
        tick();
        a_err_clr = 1'b0;
        tick();
        a_in_ohc = 9'(1) << 7;
        tick();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        #2;
        vectors++;
        if (a_out_valid !== 1'b1 || a_out_bin !== 4'd7 || a_err_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL arst_pre: valid=%b bin=%0d cnt=%0d, required 1/7/1", a_out_valid, a_out_bin, a_err_cnt);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (a_out_valid !== 1'b0 || a_out_bin !== 4'd0 || a_out_err !== 1'b0
            || a_err_cnt !== 8'd0 || a_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_now: valid=%b bin=%0d err=%b cnt=%0d rdy=%b, required 0/0/0/0/1",
                     a_out_valid, a_out_bin, a_out_err, a_err_cnt, a_in_ready);
        end
        #1;
        rst_n = 1'b1;
        tick();
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        a_in_ohc    = 9'(1) << 3;
        tick();
        vectors++;
        if (a_out_valid !== 1'b1 || a_out_bin !== 4'd3 || a_out_err !== 1'b0 || a_err_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL arst_after: valid=%b bin=%0d err=%b cnt=%0d, required 1/3/0/0",
                     a_out_valid, a_out_bin, a_out_err, a_err_cnt);
        end
        a_in_valid = 1'b0;
        tick();
    endtask

    initial begin
        clk = 1'b0;
        vectors = 0;
        miscompares = 0;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_err_clr = 1'b0; a_in_ohc = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_err_clr = 1'b0; s_in_ohc = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_err_clr = 1'b0; b_in_ohc = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b1; c_err_clr = 1'b0; c_in_ohc = '0;

        test_reset();
        test_stream();
        test_malformed();
        test_backpressure();
        test_saturation();
        test_param();
        test_random();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ohc_to_binary_pipe.md
# ohc_to_binary_pipe

Parametrised, registered one-hot-code (OHC) to binary converter for the RNS modulo-adder datapath. It converts an M-bit one-hot residue into a ceil(log2 M)-bit binary value behind a valid/ready handshake. It flags and counts malformed codes, meaning zero hot bits or more than one hot bit. It sits between the OHC modulo adders and the binary residue consumers, and replaces the fixed 9-bit combinational converter, which emits X on bad input.

## Interface
Parameters:
- M, default 9: modulus, which is the one-hot width; legal range 2..64.
- OUT_W, default $clog2(M): binary output width; derived, do not override.
- ERR_CNT_W, default 8: width of the saturating error counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset.
- in_valid  in  1  upstream asserts that in_ohc is valid.
- in_ready  out  1  block can accept a code this cycle.
- in_ohc  in  M  one-hot residue; bit k set means residue value k.
- out_valid  out  1  out_bin and out_err hold a converted result.
- out_ready  in  1  downstream accepts the result.
- out_bin  out  OUT_W  binary residue, 0..M-1.
- out_err  out  1  the result came from a malformed code.
- err_clr  in  1  synchronous clear of err_cnt.
- err_cnt  out  ERR_CNT_W  saturating count of malformed codes accepted.

## Operation
- Accept condition: in_valid && in_ready.
- Conversion on accept, combinational then registered:
  - popcount(in_ohc) == 1: out_bin = index of the set bit, out_err = 0.
  - popcount is 0 or greater than 1: out_bin = 0, out_err = 1.
  - Output is never X.
- Output register stage is a single-entry pipeline register. States:
  - EMPTY: out_valid = 0. An accept loads the register and moves to FULL.
  - FULL: out_valid = 1.
    - out_ready = 1 with a new accept: register reloads, stays FULL.
    - out_ready = 1 with no accept: moves to EMPTY.
    - out_ready = 0: register holds and stays FULL. out_bin and out_err must stay stable while out_valid && !out_ready.
- in_ready = !out_valid || out_ready. This is combinational from out_ready; no skid buffer.
- Error counter:
  - Increments by 1 on each accept whose code is malformed.
  - Saturates at 2^ERR_CNT_W - 1 and does not wrap.
  - err_clr = 1 sets err_cnt to 0 on the next edge.
  - If err_clr and a malformed accept fall in the same cycle, the clear wins: err_cnt = 0 and that error is not counted.
- Bits of in_ohc are only meaningful when in_valid = 1. Values on non-accept cycles do not affect any state.

## Timing
- Reset (rst_n = 0, asynchronous) sets out_valid = 0, out_bin = 0, out_err = 0, err_cnt = 0. in_ready = 1 while in reset and immediately after.
- Latency: a code accepted at edge n appears on out_bin/out_valid after edge n, i.e. a 1-cycle latency.
- Throughput: 1 code per cycle when out_ready is held at 1.
- Backpressure: with out_ready = 0 and out_valid = 1, in_ready = 0. No accept occurs and no counter update occurs.
- Reset asserted mid-transfer drops any held result with no handshake completion. The first accept after reset release behaves as from EMPTY.
- err_cnt updates on the same edge as the accept that caused it. It is visible in the same cycle out_err first shows 1.

## Test plan
- Reset, then for M = 9, stream in_ohc = 9'b000000001 … 9'b100000000 with out_ready = 1 -> out_bin = 0..8 on consecutive cycles, out_err = 0, in_ready held at 1, err_cnt = 0.
- Malformed codes, M = 9: send 9'b000000000 then 9'b000010010 -> both outputs have out_bin = 0, out_err = 1; err_cnt reads 1 then 2.
- Backpressure: accept 9'b000100000 (out_bin = 5), hold out_ready = 0 for 4 cycles while in_valid = 1 with 9'b000000100 -> out_bin stays 5 and in_ready = 0. Releasing out_ready -> 5 is consumed and 2 is accepted in the same cycle, then appears next cycle.
- Saturation and clear, ERR_CNT_W = 3: send 10 malformed codes -> err_cnt stops at 7. Assert err_clr in the same cycle as an 11th malformed accept -> err_cnt = 0.
- Parametrisation: M = 2 (OUT_W = 1) and M = 17 (OUT_W = 5), exhaustive legal one-hot inputs -> out_bin equals the bit index. 2'b11 for M = 2 gives out_err = 1.
- Async reset mid-stream: assert rst_n = 0 between clock edges while out_valid = 1 -> out_valid, out_bin, out_err and err_cnt go to 0 immediately, without waiting for an edge.
